// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM states, default
// parameter values and internal counter widths.
package spi_pkg;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_TIMEOUT    = 255;

  // Timeout counter is 16 bits so TIMEOUT up to 65535 never wraps.
  localparam int TMO_W = 16;
  // Gap counter covers GAP_CYCLES up to 255.
  localparam int GAP_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first asserted request at or
// after 'pointer' (wrapping) wins. Produces one-hot winner, its index and
// an any-request flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            any
);

  // Requests rotated so that bit 0 is the requester at 'pointer'.
  logic [NREQ-1:0] rot;

  assign rot = NREQ'({req, req} >> pointer);

  // Scan from the far end so the lowest rotated position overrides.
  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any = 1'b1;
        if (int'(pointer) + j >= NREQ) begin
          index = IW'(int'(pointer) + j - NREQ);
        end else begin
          index = IW'(int'(pointer) + j);
        end
      end
    end
    if (any) begin
      winner = NREQ'(1) << index;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between NREQ requesters. Grants round-robin,
// launches one word per grant, waits for the master's end-of-frame or a
// timeout, then forces an idle gap before the next grant.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [NREQ-1:0]        cs_sel,
  output logic                   m_tx_enable,
  output logic [DATA_W-1:0]      m_tx_data,
  input  logic                   m_busy,
  input  logic                   m_done
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              err_q;
  logic              tx_en_q;
  logic [DATA_W-1:0] data_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_d;
  logic [GAP_W-1:0]  gap_q;

  logic [NREQ-1:0]   arb_onehot;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req),
    .pointer (ptr_q),
    .winner  (arb_onehot),
    .index   (arb_idx),
    .any     (arb_any)
  );

  assign win_data = req_data[arb_idx*DATA_W +: DATA_W];
  assign tmo_d    = tmo_q + TMO_W'(1);
  // Next search starts just past the winner, wrapping at NREQ.
  assign ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tx_en_q <= 1'b0;
      data_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q  <= '0;
      err_q   <= 1'b0;
      tx_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any && !m_busy) begin
            gnt_q   <= arb_onehot;
            data_q  <= win_data;
            ptr_q   <= ptr_d;
            tx_en_q <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tmo_q <= tmo_d;
          // End-of-frame takes priority over a coincident timeout.
          if (m_done) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end else if (tmo_d == TMO_W'(TIMEOUT)) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign cs_sel      = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_tx_enable = tx_en_q;
  assign m_tx_data   = data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: directed scenarios plus
// randomized transactions compared against a transaction-level model.
module tb_spi_master_arbiter;

  localparam int NREQ       = 4;
  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 40;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [NREQ-1:0]        cs_sel;
  logic                   m_tx_enable;
  logic [DATA_W-1:0]      m_tx_data;
  logic                   m_busy;
  logic                   m_done;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NREQ       (NREQ),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .cs_sel      (cs_sel),
    .m_tx_enable (m_tx_enable),
    .m_tx_data   (m_tx_data),
    .m_busy      (m_busy),
    .m_done      (m_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: round-robin pointer, per-requester words, and how many
  // cycles from "now" the earliest grant can occur (1 from idle,
  // GAP_CYCLES+1 right after a completion).
  int                ptr_m;
  int                next_base;
  logic [DATA_W-1:0] data_m [NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Winner = first requester found walking upward from the pointer.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    int rv;
    rv = int'(r);
    for (int k = 0; k < NREQ; k++) begin
      if (((rv >> ((p + k) % NREQ)) & 1) == 1) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic set_req(input logic [NREQ-1:0] r, input int d0);
    for (int i = 0; i < NREQ; i++) begin
      data_m[i] = DATA_W'($urandom);
      if (i == 0 && d0 >= 0) data_m[i] = DATA_W'(d0);
      req_data[i*DATA_W +: DATA_W] = data_m[i];
    end
    req = r;
  endtask

  // One full transaction. dly = WAIT_DONE cycle in which m_done is driven
  // (0 = never, expect timeout); busy = cycles m_busy is held high first;
  // spur = pulse m_done once outside WAIT_DONE; d0 = forced word 0 (<0 random).
  task automatic txn(input string nm, input logic [NREQ-1:0] r, input int dly,
                     input bit drop, input int busy, input bit spur, input int d0);
    int                w;
    int                n;
    int                expn;
    int                lim;
    bit                quiet;
    logic [NREQ-1:0]   eg;
    logic [DATA_W-1:0] ed;
    set_req(r, d0);
    w    = rr_pick(r, ptr_m);
    eg   = NREQ'(1) << w;
    ed   = data_m[w];
    expn = (busy + 1 > next_base) ? busy + 1 : next_base;
    n     = 0;
    quiet = 1'b1;
    while (gnt === '0 && n < 1000) begin
      m_busy = (n < busy);
      m_done = spur && (n == 0);
      @(negedge clk);
      n++;
      if (gnt === '0) quiet = quiet && (done === '0) && (err === 1'b0) && (m_tx_enable === 1'b0);
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    check({nm, " grant latency"}, n, expn);
    check({nm, " idle quiet"}, {31'd0, quiet}, 1);
    check({nm, " gnt"}, gnt, eg);
    check({nm, " cs_sel"}, cs_sel, eg);
    check({nm, " m_tx_data"}, m_tx_data, ed);
    check({nm, " tx_enable on"}, m_tx_enable, 1);
    // Scramble the inputs: the launched word and the grant must not follow.
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    if (drop) req = '0;
    @(negedge clk);
    check({nm, " tx_enable off"}, m_tx_enable, 0);
    lim   = (dly == 0) ? TIMEOUT : dly;
    quiet = 1'b1;
    for (int k = 1; k < lim; k++) begin
      @(negedge clk);
      quiet = quiet && (done === '0) && (err === 1'b0) && (gnt === eg) &&
              (cs_sel === eg) && (m_tx_data === ed) && (m_tx_enable === 1'b0);
    end
    check({nm, " wait hold"}, {31'd0, quiet}, 1);
    m_done = (dly != 0);
    @(negedge clk);
    m_done = 1'b0;
    check({nm, " done"}, done, (dly != 0) ? eg : '0);
    check({nm, " err"}, err, (dly != 0) ? 0 : 1);
    check({nm, " gnt cleared"}, gnt, 0);
    check({nm, " cs_sel cleared"}, cs_sel, 0);
    $display("txn %s req=%b dly=%0d gnt=%b data=%h done=%b err=%b", nm, r, dly, eg, ed, done, err);
    ptr_m     = (w + 1) % NREQ;
    next_base = GAP_CYCLES + 1;
  endtask

  // Grant, get into WAIT_DONE, then hit reset asynchronously.
  task automatic reset_mid(input string nm, input logic [NREQ-1:0] r);
    int n;
    set_req(r, -1);
    n = 0;
    while (gnt === '0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({nm, " pre-reset grant"}, gnt, NREQ'(1) << rr_pick(r, ptr_m));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check({nm, " async clear"}, {gnt, done, err, cs_sel, m_tx_enable, m_tx_data}, 0);
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    check({nm, " held clear"}, {gnt, done, err, cs_sel, m_tx_enable, m_tx_data}, 0);
    req = '0;
    rst = 1'b0;
    $display("txn %s req=%b reset during wait", nm, r);
    ptr_m     = 0;
    next_base = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  sel;
    int  dly;
    int  busy;
    bit  drop;
    bit  spur;
    logic [NREQ-1:0] r;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    ptr_m = 0;
    next_base = 1;
    repeat (3) @(negedge clk);
    check("reset outputs", {gnt, done, err, cs_sel, m_tx_enable, m_tx_data}, 0);
    rst = 1'b0;

    // All requesters held: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      txn("all_req", 4'b1111, $urandom_range(1, 10), 1'b0, 0, 1'b0, -1);
      check("rotation order", gnt | done, NREQ'(1) << (i % NREQ));
    end
    txn("single_AA", 4'b0001, 20, 1'b0, 0, 1'b0, 8'hAA);
    txn("timeout", 4'b0010, 0, 1'b0, 0, 1'b0, -1);
    txn("coincident", 4'b0001, TIMEOUT, 1'b0, 0, 1'b0, -1);
    txn("regrant", 4'b0001, 3, 1'b0, 0, 1'b1, -1);
    txn("drop_req", 4'b0100, 5, 1'b1, 0, 1'b0, -1);
    reset_mid("rst_a", 4'b0010);
    txn("after_rst", 4'b0100, 4, 1'b0, 0, 1'b0, -1);
    txn("mid_ptr", 4'b0010, 2, 1'b0, 0, 1'b0, -1);
    reset_mid("rst_b", 4'b1000);
    txn("ptr_zero", 4'b0101, 2, 1'b0, 0, 1'b0, -1);
    txn("busy", 4'b0001, 6, 1'b0, 8, 1'b0, -1);

    for (int t = 0; t < 30; t++) begin
      sel  = $urandom_range(0, 9);
      dly  = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : $urandom_range(1, 25);
      r    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drop = ($urandom_range(0, 3) == 0);
      busy = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      spur = ($urandom_range(0, 1) == 1);
      txn("rand", r, dly, drop, busy, spur, -1);
    end

    req = '0;
    repeat (GAP_CYCLES + 3) @(negedge clk);
    check("final idle", {gnt, done, err, cs_sel, m_tx_enable}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
